// File: rtl/epc_stack.sv
// Nested exception-context stack {epc, code, bd}: push on exception, pop on ERET.
// Optional macro EPC_BD_ADJUST_EN: branch-delay faults store exc_pc-4 as the EPC.
module epc_stack #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 4,
  parameter  int CODE_W = 5,
  localparam int LVL_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_req,
  input  logic [WIDTH-1:0]  exc_pc,
  input  logic [CODE_W-1:0] exc_code,
  input  logic              exc_bd,
  input  logic              eret,
  input  logic              mtc0_we,
  input  logic [WIDTH-1:0]  mtc0_data,
  output logic [WIDTH-1:0]  epc_out,
  output logic [CODE_W-1:0] code_out,
  output logic              bd_out,
  output logic [LVL_W-1:0]  level,
  output logic              exl,
  output logic              overflow
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  logic [DEPTH-1:0][WIDTH-1:0]  epc_q;
  logic [DEPTH-1:0][CODE_W-1:0] code_q;
  logic [DEPTH-1:0]             bd_q;
  logic [LVL_W-1:0]             level_q, level_d;
  logic                         ovf_q, ovf_d;

  logic                         push_en, mtc_en;
  logic [LVL_W-1:0]             wr_idx;
  logic [WIDTH-1:0]             push_epc;

`ifdef EPC_BD_ADJUST_EN
  // Point EPC back at the branch so the whole branch/delay pair re-executes.
  assign push_epc = exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;
`else
  assign push_epc = exc_pc;
`endif

  always_comb begin
    push_en = 1'b0;
    mtc_en  = 1'b0;
    wr_idx  = '0;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (exc_req && eret) begin
      // Exception on the ERET itself: the returning context is replaced.
      push_en = 1'b1;
      if (level_q == '0) begin
        level_d = LVL_ONE;
      end else begin
        wr_idx = level_q - LVL_ONE;
      end
    end else if (exc_req) begin
      push_en = 1'b1;
      if (level_q < LVL_MAX) begin
        wr_idx  = level_q;
        level_d = level_q + LVL_ONE;
      end else begin
        wr_idx = LVL_MAX - LVL_ONE;
        ovf_d  = 1'b1;
      end
    end else if (eret) begin
      if (level_q != '0) level_d = level_q - LVL_ONE;
    end else if (mtc0_we && level_q != '0) begin
      mtc_en = 1'b1;
      wr_idx = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q   <= '0;
      code_q  <= '0;
      bd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_en && wr_idx == LVL_W'(i)) begin
          epc_q[i]  <= push_epc;
          code_q[i] <= exc_code;
          bd_q[i]   <= exc_bd;
        end else if (mtc_en && wr_idx == LVL_W'(i)) begin
          epc_q[i] <= mtc0_data;
        end
      end
    end
  end

  // Top-of-stack select; reads as zero when the stack is empty.
  always_comb begin
    epc_out  = '0;
    code_out = '0;
    bd_out   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level_q == LVL_W'(i+1)) begin
        epc_out  = epc_q[i];
        code_out = code_q[i];
        bd_out   = bd_q[i];
      end
    end
  end

  assign level    = level_q;
  assign exl      = (level_q != '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_epc_stack.sv
// Directed bench for epc_stack (WIDTH=32, DEPTH=4); BD expectations follow EPC_BD_ADJUST_EN.
module tb_epc_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req, exc_bd, eret, mtc0_we;
  logic [31:0] exc_pc, mtc0_data;
  logic [4:0]  exc_code;
  logic [31:0] epc_out;
  logic [4:0]  code_out;
  logic        bd_out, exl, overflow;
  logic [2:0]  level;

  int n_run = 0;
  int n_fail = 0;

  epc_stack #(.WIDTH(32), .DEPTH(4), .CODE_W(5)) dut (
    .clk(clk), .reset(reset),
    .exc_req(exc_req), .exc_pc(exc_pc), .exc_code(exc_code), .exc_bd(exc_bd),
    .eret(eret), .mtc0_we(mtc0_we), .mtc0_data(mtc0_data),
    .epc_out(epc_out), .code_out(code_out), .bd_out(bd_out),
    .level(level), .exl(exl), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exc_req = 1'b0; eret = 1'b0; mtc0_we = 1'b0; exc_bd = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] code, input logic bd);
    exc_req = 1'b1; exc_pc = pc; exc_code = code; exc_bd = bd;
    tick();
  endtask

  task automatic pop();
    eret = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic chk_top(input string tag, input logic [31:0] e_epc, input logic [2:0] e_lvl);
    chk({tag, ".epc"}, epc_out, e_epc);
    chk({tag, ".level"}, 32'(level), 32'(e_lvl));
    chk({tag, ".exl"}, 32'(exl), 32'(e_lvl != 3'd0));
  endtask

  initial begin
    reset = 1'b0; exc_req = 1'b0; exc_bd = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
    exc_pc = '0; mtc0_data = '0; exc_code = '0;

    // reset and idle
    #2;
    chk_top("rst", 32'h0, 3'd0);
    chk("rst.ovf", 32'(overflow), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk_top("idle", 32'h0, 3'd0);
    chk("idle.ovf", 32'(overflow), 32'h0);
    chk("idle.code", 32'(code_out), 32'h0);

    // nested push / pop
    push(32'h100, 5'd4, 1'b0);
    chk_top("p1", 32'h100, 3'd1);
    push(32'h200, 5'd8, 1'b0);
    chk_top("p2", 32'h200, 3'd2);
    push(32'h300, 5'd12, 1'b0);
    chk_top("p3", 32'h300, 3'd3);
    chk("p3.code", 32'(code_out), 32'd12);
    pop();
    chk_top("e1", 32'h200, 3'd2);
    chk("e1.code", 32'(code_out), 32'd8);
    pop();
    chk_top("e2", 32'h100, 3'd1);
    chk("e2.code", 32'(code_out), 32'd4);
    pop();
    chk_top("e3", 32'h0, 3'd0);
    chk("e3.code", 32'(code_out), 32'h0);
    pop();
    chk_top("e4", 32'h0, 3'd0);
    chk("e4.ovf", 32'(overflow), 32'h0);

    // overflow at DEPTH
    push(32'h10, 5'd1, 1'b0);
    push(32'h20, 5'd1, 1'b0);
    push(32'h30, 5'd1, 1'b0);
    push(32'h40, 5'd1, 1'b0);
    chk_top("full", 32'h40, 3'd4);
    chk("full.ovf", 32'(overflow), 32'h0);
    push(32'h50, 5'd2, 1'b0);
    chk_top("ovf", 32'h50, 3'd4);
    chk("ovf.flag", 32'(overflow), 32'h1);
    pop();
    chk_top("ovf.pop", 32'h30, 3'd3);
    chk("ovf.sticky", 32'(overflow), 32'h1);
    do_reset();
    chk("ovf.rst", 32'(overflow), 32'h0);

    // async reset mid-cycle
    push(32'h11, 5'd1, 1'b0);
    push(32'h22, 5'd1, 1'b0);
    chk_top("ar.pre", 32'h22, 3'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_top("ar.async", 32'h0, 3'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // exception on ERET
    push(32'h100, 5'd1, 1'b0);
    push(32'h200, 5'd2, 1'b0);
    exc_req = 1'b1; eret = 1'b1; exc_pc = 32'h400; exc_code = 5'd3;
    tick();
    chk_top("xe", 32'h400, 3'd2);
    chk("xe.code", 32'(code_out), 32'd3);
    chk("xe.ovf", 32'(overflow), 32'h0);
    pop();
    chk_top("xe.pop", 32'h100, 3'd1);
    pop();
    exc_req = 1'b1; eret = 1'b1; exc_pc = 32'h500; exc_code = 5'd6;
    tick();
    chk_top("xe.l0", 32'h500, 3'd1);
    // at full depth, replace without flagging overflow
    push(32'h600, 5'd1, 1'b0);
    push(32'h610, 5'd1, 1'b0);
    push(32'h620, 5'd1, 1'b0);
    exc_req = 1'b1; eret = 1'b1; exc_pc = 32'h630; exc_code = 5'd7;
    tick();
    chk_top("xe.full", 32'h630, 3'd4);
    chk("xe.full.ovf", 32'(overflow), 32'h0);
    pop(); pop(); pop();
    chk_top("xe.back", 32'h500, 3'd1);

    // MTC0
    mtc0_we = 1'b1; mtc0_data = 32'hABC;
    tick();
    chk_top("mtc", 32'hABC, 3'd1);
    chk("mtc.code", 32'(code_out), 32'd6);
    pop();
    mtc0_we = 1'b1; mtc0_data = 32'h777;
    tick();
    chk_top("mtc.l0", 32'h0, 3'd0);
    exc_req = 1'b1; exc_pc = 32'h700; exc_code = 5'd9; mtc0_we = 1'b1; mtc0_data = 32'h999;
    tick();
    chk_top("mtc.push", 32'h700, 3'd1);
    push(32'h800, 5'd10, 1'b0);
    eret = 1'b1; mtc0_we = 1'b1; mtc0_data = 32'h999;
    tick();
    chk_top("mtc.eret", 32'h700, 3'd1);

    // branch-delay handling
    push(32'h104, 5'd2, 1'b1);
`ifdef EPC_BD_ADJUST_EN
    chk_top("bd", 32'h100, 3'd2);
`else
    chk_top("bd", 32'h104, 3'd2);
`endif
    chk("bd.flag", 32'(bd_out), 32'h1);
    push(32'h0, 5'd2, 1'b1);
`ifdef EPC_BD_ADJUST_EN
    chk_top("bd.wrap", 32'hFFFF_FFFC, 3'd3);
`else
    chk_top("bd.wrap", 32'h0, 3'd3);
`endif
    chk("bd.wrap.flag", 32'(bd_out), 32'h1);
    pop();
    push(32'h104, 5'd2, 1'b0);
    chk_top("bd.off", 32'h104, 3'd3);
    chk("bd.off.flag", 32'(bd_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/epc_stack.md
# epc_stack

Parametrised exception-context register file for the CPU's CP0 path. It replaces the single EPC register with a DEPTH-entry stack of {EPC, exception code, branch-delay flag}, so nested exceptions do not clobber their return addresses. The block pushes a context on each taken exception and pops it on ERET. The top entry drives the return PC to the fetch stage and the status fields to CP0 reads.

## Interface
- WIDTH, 32, PC/EPC width in bits (≥ 8, multiple of 4)
- DEPTH, 4, number of nested contexts held (≥ 1)
- CODE_W, 5, exception-code width
- LVL_W, $clog2(DEPTH+1), level-counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (state cleared while 0)
- exc_req  in  1  exception taken this cycle; push context
- exc_pc  in  WIDTH  PC of the faulting instruction
- exc_code  in  CODE_W  exception cause code
- exc_bd  in  1  faulting instruction sits in a branch delay slot
- eret  in  1  ERET retires this cycle; pop context
- mtc0_we  in  1  software write of EPC (MTC0)
- mtc0_data  in  WIDTH  value for the top entry's EPC
- epc_out  out  WIDTH  EPC of the top entry; 0 when level==0
- code_out  out  CODE_W  exception code of the top entry; 0 when level==0
- bd_out  out  1  BD flag of the top entry; 0 when level==0
- level  out  LVL_W  number of valid entries, 0..DEPTH
- exl  out  1  level != 0
- overflow  out  1  sticky: an exception arrived while level==DEPTH

## Operation
- State: entry[0..DEPTH-1] of {epc, code, bd}, level counter, overflow flag. The top entry is entry[level-1].
- The block has no FSM. Each cycle's action is chosen by priority: exc_req&eret, then exc_req, then eret, then mtc0_we.
- Push (exc_req only):
  - level<DEPTH: write entry[level]; level+1.
  - level==DEPTH: overwrite entry[DEPTH-1]; level unchanged; overflow<=1.
- Pop (eret only):
  - level>0: level-1. The popped entry keeps its stale contents.
  - level==0: ignored. No state change, no flag.
- exc_req and eret together (exception on the ERET): replace the top entry; level unchanged.
  - If level==0, this is a normal push to level 1.
  - overflow is not set in this case.
- mtc0_we: write mtc0_data to the top entry's epc.
  - Ignored when level==0.
  - Ignored when exc_req or eret is active in the same cycle.
- Stored epc: exc_pc, or exc_pc-4 when adjusted (see Configuration). Arithmetic is modulo 2^WIDTH.
- overflow clears only on reset.
- Outputs are combinational decodes of registered state only. There is no input-to-output combinational path.

## Timing
- Reset (reset==0, asynchronous): level=0, all entries 0, overflow=0. All outputs read 0.
- Reset deassertion must be synchronous to clk at the top level. The block does not resynchronise it.
- Latency: an event sampled at edge N is visible on the outputs after edge N, i.e. during cycle N+1.
- Pushes may occur every cycle. Back-to-back push and pop need no bubbles.
- Reset asserted mid-sequence discards all contexts immediately, regardless of clk.

## Configuration
- EPC_BD_ADJUST_EN defined:
  - When exc_bd==1, stored epc = exc_pc-4 (the branch address) and stored bd = 1.
  - exc_pc=0 with exc_bd=1 stores 2^WIDTH-4.
- EPC_BD_ADJUST_EN undefined:
  - Stored epc = exc_pc unconditionally.
  - Stored bd = exc_bd, recorded for software only.

## Test plan
- Reset and idle:
  - reset low, then high, no stimulus -> level=0, exl=0, epc_out=0, overflow=0.
  - Assert reset between clock edges after two pushes -> outputs drop to 0 without a clk edge.
- Nested push/pop:
  - Push pc 0x100 (code 4), then 0x200 (code 8), then 0x300 (code 12) -> level=3, epc_out=0x300.
  - Three erets -> epc_out reads 0x200, then 0x100, then 0.
  - A fourth eret at level 0 -> no change.
- Overflow (DEPTH=4):
  - Five pushes of 0x10, 0x20, 0x30, 0x40, 0x50 -> level=4, epc_out=0x50, overflow=1.
  - Pop once -> epc_out=0x30.
- Simultaneous exc_req and eret at level 2 (top 0x200), new pc 0x400 -> level=2, epc_out=0x400, overflow=0.
- MTC0:
  - mtc0_we with data 0xABC at level 1 -> epc_out=0xABC.
  - mtc0_we at level 0 -> ignored.
  - mtc0_we together with exc_req -> push wins; pushed epc is shown.
- BD adjust:
  - exc_pc=0x104, exc_bd=1 -> epc_out=0x100, bd_out=1 with EPC_BD_ADJUST_EN; epc_out=0x104, bd_out=1 without.
  - exc_pc=0, exc_bd=1 with EPC_BD_ADJUST_EN -> epc_out=0xFFFFFFFC.
